// File: rtl/aes_round_engine_pkg.sv
// Shared AES types and tables for the round engine: S-box, GF(2^8) xtime,
// 16-byte state type and the engine FSM encoding.
package aes_round_engine_pkg;

    typedef logic [15:0][7:0] aes_state_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} aes_eng_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_engine_if.sv
// Block-in / block-out handshakes plus the key-expander link of the round engine.
interface aes_round_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         key_load;
    logic [127:0] k_sch;
    logic [4:0]   key_avail;

    modport master (
        output in_valid, in_block, out_ready, k_sch, key_avail,
        input  in_ready, out_valid, out_block, key_load
    );

    modport slave (
        input  in_valid, in_block, out_ready, k_sch, key_avail,
        output in_ready, out_valid, out_block, key_load
    );
endinterface

// File: rtl/aes_mix_column.sv
// AES MixColumns on one 32-bit column; byte 0 (row 0) sits in bits [7:0].
module aes_mix_column
    import aes_round_engine_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);
    logic [7:0] a0, a1, a2, a3;

    assign {a3, a2, a1, a0} = col_in;

    // 3*b is expressed as xtime(b) ^ b
    assign col_out[7:0]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign col_out[15:8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign col_out[31:24] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encryption, one round per clock, paced by the key expander.
// Optional key-sync error check: define AES_ROUND_ENGINE_KEYCHK_EN.
module aes_round_engine
    import aes_round_engine_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_round_engine_if.slave bus,
    output logic              busy,
    output logic              key_err
);
    localparam logic [4:0] LAST_RND = 5'(Nr);

    function automatic aes_state_t sub_bytes(input aes_state_t s);
        aes_state_t r;
        for (int i = 0; i < 16; i++) r[i] = SBOX[s[i]];
        return r;
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t r;
        for (int row = 0; row < 4; row++)
            for (int c = 0; c < 4; c++)
                r[row + 4*c] = s[row + 4*((c + row) % 4)];
        return r;
    endfunction

    aes_eng_state_e st_q, st_d;
    aes_state_t     st, sr, mc, rnd_out;
    logic [4:0]     rnd;
    logic           key_hit, last, key_load, out_valid;
    logic [127:0]   out_block;

    assign sr = shift_rows(sub_bytes(st));

    for (genvar c = 0; c < 4; c++) begin : g_mix
        aes_mix_column u_mix (.col_in(sr[4*c +: 4]), .col_out(mc[4*c +: 4]));
    end

    assign key_hit = bus.key_avail == rnd;
    assign last    = rnd == LAST_RND;
    assign rnd_out = (last ? sr : mc) ^ bus.k_sch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= IDLE;
        else        st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    if (bus.in_valid)                st_d = LOAD;
            LOAD:    if (bus.key_avail == 5'd0)       st_d = RUN;
            RUN:     if (key_hit && last)             st_d = DONE;
            DONE:    if (bus.out_ready)               st_d = IDLE;
            default:                                  st_d = IDLE;
        endcase
    end

    // Round progress is gated purely on key_avail; a mismatch is a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= '0;
            rnd       <= '0;
            key_load  <= 1'b0;
            out_valid <= 1'b0;
            out_block <= '0;
        end else begin
            case (st_q)
                IDLE: if (bus.in_valid) begin
                    st       <= bus.in_block;
                    key_load <= 1'b1;
                end
                LOAD: if (bus.key_avail == 5'd0) begin
                    st  <= st ^ bus.k_sch;
                    rnd <= 5'd1;
                end
                RUN: if (key_hit) begin
                    st  <= rnd_out;
                    rnd <= rnd + 5'd1;
                    if (last) begin
                        key_load  <= 1'b0;
                        out_valid <= 1'b1;
                        out_block <= rnd_out;
                    end
                end
                DONE: if (bus.out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = st_q == IDLE;
    assign bus.out_valid = out_valid;
    assign bus.out_block = out_block;
    assign bus.key_load  = key_load;
    assign busy          = st_q != IDLE;

`ifdef AES_ROUND_ENGINE_KEYCHK_EN
    // The restart code 16 also exceeds every round index, so one compare covers both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   key_err <= 1'b0;
        else if (st_q == RUN && bus.key_avail > rnd)  key_err <= 1'b1;
    end
`else
    assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine with a behavioural key-expander stub per instance.
module tb_aes_round_engine;
    import aes_round_engine_pkg::*;

    localparam logic [127:0] PT     = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [255:0] KEY128 = 256'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [255:0] KEY256 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] CT4    = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] CT8    = 128'h8960494b9049fceabf456751cab7a28e;
`ifdef AES_ROUND_ENGINE_KEYCHK_EN
    localparam logic KERR = 1'b1;
`else
    localparam logic KERR = 1'b0;
`endif

    logic clk, rst_n;
    logic busy4, kerr4, busy8, kerr8;
    logic [4:0] av4, av8;
    logic freeze, glitch;
    logic [127:0] rk4 [32];
    logic [127:0] rk8 [32];
    int n_err = 0, n_chk = 0, cyc = 0, t0 = 0;

    aes_round_engine_if bus4();
    aes_round_engine_if bus8();

    aes_round_engine #(.Nk(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .busy(busy4), .key_err(kerr4));
    aes_round_engine #(.Nk(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8), .busy(busy8), .key_err(kerr8));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < 4*r + 4; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[7:0], t[31:8]}) ^ {24'h0, rc};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endfunction

    // Expander stubs: restart on load, then one key index per cycle up to Nr.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                av4 <= 5'd16;
        else if (!bus4.key_load)                   av4 <= 5'd16;
        else if (av4 == 5'd16)                     av4 <= 5'd0;
        else if (!freeze && !glitch && av4 < 5'd10) av4 <= av4 + 5'd1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  av8 <= 5'd16;
        else if (!bus8.key_load)     av8 <= 5'd16;
        else if (av8 == 5'd16)       av8 <= 5'd0;
        else if (av8 < 5'd14)        av8 <= av8 + 5'd1;
    end
    assign bus4.key_avail = glitch ? 5'd5 : av4;
    assign bus4.k_sch     = rk4[bus4.key_avail];
    assign bus8.key_avail = av8;
    assign bus8.k_sch     = rk8[bus8.key_avail];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send4();
        int k = 0;
        while (!bus4.in_ready && k < 200) begin tick(); k++; end
        bus4.in_block = PT;
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_out4(input string tag, input int exp_lat);
        int k = 0;
        while (!bus4.out_valid && k < 200) begin tick(); k++; end
        chk({tag, "_lat"}, cyc - t0, exp_lat);
        chk({tag, "_ct"}, bus4.out_block, CT4);
    endtask

    task automatic drain4();
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        chk("drain_ov", bus4.out_valid, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},  bus4.in_ready,  1'b1);
        chk({tag, "_out_valid"}, bus4.out_valid, 1'b0);
        chk({tag, "_key_load"},  bus4.key_load,  1'b0);
        chk({tag, "_out_block"}, bus4.out_block, '0);
        chk({tag, "_busy"},      busy4,          1'b0);
        chk({tag, "_key_err"},   kerr4,          1'b0);
    endtask

    initial begin
        int k, n_acc, n_out, last_out, lowrun;
        logic seen_high;
        for (int r = 0; r < 32; r++) begin rk4[r] = '0; rk8[r] = '0; end
        for (int r = 0; r <= 10; r++) rk4[r] = round_key(KEY128, 4, r);
        for (int r = 0; r <= 14; r++) rk8[r] = round_key(KEY256, 8, r);
        rst_n = 1'b0; freeze = 1'b0; glitch = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_block = '0; bus4.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_block = '0; bus8.out_ready = 1'b0;
        tick(); tick();
        chk_reset("rst");
        chk("rst8_in_ready", bus8.in_ready, 1'b1);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy4, 1'b0);

        // 1: AES-128 known answer and latency
        send4();
        chk("t1_busy", busy4, 1'b1);
        chk("t1_in_ready", bus4.in_ready, 1'b0);
        wait_out4("t1", 12);
        chk("t1_key_load_done", bus4.key_load, 1'b0);
        drain4();
        chk("t1_idle_in_ready", bus4.in_ready, 1'b1);

        // 2: AES-256 known answer and latency
        bus8.in_block = PT;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        t0 = cyc;
        k = 0;
        while (!bus8.out_valid && k < 200) begin tick(); k++; end
        chk("t2_lat", cyc - t0, 16);
        chk("t2_ct", bus8.out_block, CT8);
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        chk("t2_drain", bus8.out_valid, 1'b0);

        // 3: output back-pressure with a second block pending
        send4();
        wait_out4("t3a", 12);
        bus4.in_block = PT;
        bus4.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("t3_hold_ct", bus4.out_block, CT4);
            chk("t3_hold_in_ready", bus4.in_ready, 1'b0);
            tick();
        end
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        chk("t3_handshake_ov", bus4.out_valid, 1'b0);
        chk("t3_handshake_in_ready", bus4.in_ready, 1'b1);
        tick();
        bus4.in_valid = 1'b0;
        t0 = cyc;
        chk("t3_second_busy", busy4, 1'b1);
        wait_out4("t3b", 12);
        drain4();

        // 4: three blocks back to back
        bus4.in_block = PT;
        bus4.in_valid = 1'b1;
        bus4.out_ready = 1'b1;
        n_acc = 0; n_out = 0; last_out = 0; lowrun = 0; seen_high = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (n_acc == 3) bus4.in_valid = 1'b0;
            if (bus4.in_valid && bus4.in_ready) n_acc++;
            if (bus4.out_valid) begin
                chk("t4_ct", bus4.out_block, CT4);
                if (n_out > 0) chk("t4_spacing", cyc - last_out, 14);
                last_out = cyc;
                n_out++;
            end
            if (bus4.key_load) begin
                if (seen_high && lowrun > 0) chk("t4_key_load_gap_ge2", lowrun >= 2, 1'b1);
                lowrun = 0;
                seen_high = 1'b1;
            end else begin
                lowrun++;
            end
            tick();
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b0;
        chk("t4_n_out", n_out, 3);

        // 5: reset in the middle of round 5
        send4();
        k = 0;
        while (bus4.key_avail != 5'd5 && k < 50) begin tick(); k++; end
        chk("t5_reach_k5", bus4.key_avail, 5'd5);
        rst_n = 1'b0;
        #1;
        chk_reset("t5_rst");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t5_after_ov", bus4.out_valid, 1'b0);
        send4();
        wait_out4("t5", 12);
        drain4();

        // 6: expander stall, then a skipped key index
        send4();
        k = 0;
        while (bus4.key_avail != 5'd3 && k < 50) begin tick(); k++; end
        chk("t6_reach_k3", bus4.key_avail, 5'd3);
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_stall_kerr", kerr4, 1'b0);
            chk("t6_stall_ov", bus4.out_valid, 1'b0);
        end
        glitch = 1'b1;
        tick();
        chk("t6_jump_kerr", kerr4, KERR);
        glitch = 1'b0;
        freeze = 1'b0;
        wait_out4("t6", 17);
        chk("t6_kerr_sticky", kerr4, KERR);
        drain4();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
